// File: rtl/buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter
//
// Shares the single buzzer note path between three note sources. Fixed priority
// (req[0] keyboard > req[1] learning > req[2] auto-play) with a minimum hold
// time, so a short key tap is still audible and preemption cannot chop a note
// into clicks. All outputs are registered.
//
// Optional feature macro: BUZZER_ARBITER_GAP_EN
//   defined   : every release passes through a silent GAP of GAP_CYCLES cycles,
//               then one IDLE cycle, before anyone is granted again.
//   undefined : no GAP state or gap counter; handover to the next requester is
//               direct, with no silent cycle.
//
// Parameters
//   MIN_HOLD   minimum cycles a granted note sounds before release (>= 1)
//   GAP_CYCLES silent cycles between grants (gap build only)
//   CNT_W      width of hold/gap counters; must hold max(MIN_HOLD, GAP_CYCLES)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req[2:0]   request per source, bit0 highest priority
//   note_in    4-bit note per source, source i at [4i+3:4i]
//   grant      one-hot current owner, 0 when silent
//   note_out   latched note of the owner for the tone generator
//   play_out   buzzer enable, equals (grant != 0)
//   busy       high whenever the arbiter is not idle
//   preempted  one-cycle pulse to the owner that lost the buzzer while its
//              request was still high
// -----------------------------------------------------------------------------
module buzzer_arbiter #(
    parameter int unsigned MIN_HOLD   = 2_000_000,
    parameter int unsigned GAP_CYCLES = 500_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] note_in,
    output logic [2:0]  grant,
    output logic [3:0]  note_out,
    output logic        play_out,
    output logic        busy,
    output logic [2:0]  preempted
);

    localparam longint unsigned CNT_CAP = (64'd1 << CNT_W) - 64'd1;
    localparam longint unsigned CNT_MAX = (MIN_HOLD > GAP_CYCLES) ? MIN_HOLD : GAP_CYCLES;

    // Reject configurations the counters cannot represent.
    generate
        if (MIN_HOLD < 1 || GAP_CYCLES < 1 || CNT_MAX > CNT_CAP) begin : g_bad_cfg
            $error("buzzer_arbiter: MIN_HOLD/GAP_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);
`ifdef BUZZER_ARBITER_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY
`ifdef BUZZER_ARBITER_GAP_EN
        ,
        S_GAP
`endif
    } state_t;

    state_t             r_state;
    logic [2:0]         r_grant;
    logic [3:0]         r_note;
    logic               r_play;
    logic               r_busy;
    logic [2:0]         r_preempt;
    logic [CNT_W-1:0]   r_hold_cnt;
`ifdef BUZZER_ARBITER_GAP_EN
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   w_gap_next;
`endif

    state_t             w_state_next;
    logic [2:0]         w_grant_next;
    logic [3:0]         w_note_next;
    logic [2:0]         w_preempt_next;
    logic [CNT_W-1:0]   w_hold_next;

    logic [3:0]         w_note_src [3];
    logic [2:0]         w_req_first;
    logic [3:0]         w_first_note;
    logic [3:0]         w_owner_note;
    logic               w_own_req;
    logic               w_higher_req;
    logic               w_eligible;
    logic               w_release;

    // Split the packed note bus into one note per source.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign w_note_src[gi] = note_in[4*gi +: 4];
        end
    endgenerate

    // Lowest set bit of req is the highest-priority requester.
    assign w_req_first  = req & (~req + 3'd1);
    // r_grant - 1 is a mask of all sources with higher priority than the owner.
    assign w_higher_req = |(req & (r_grant - 3'd1));
    assign w_own_req    = |(req & r_grant);
    assign w_eligible   = (r_hold_cnt == HOLD_MAX);
    assign w_release    = w_eligible && (!w_own_req || w_higher_req);

    always_comb begin
        w_first_note = 4'd0;
        w_owner_note = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (w_req_first[i]) w_first_note = w_note_src[i];
            if (r_grant[i])     w_owner_note = w_note_src[i];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_note_next    = r_note;
        w_hold_next    = r_hold_cnt;
        w_preempt_next = 3'b000;
`ifdef BUZZER_ARBITER_GAP_EN
        w_gap_next     = r_gap_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (req != 3'b000) begin
                    w_state_next = S_PLAY;
                    w_grant_next = w_req_first;
                    w_note_next  = w_first_note;
                    w_hold_next  = '0;
                end
            end
            S_PLAY: begin
                if (w_release) begin
                    w_preempt_next = r_grant & req;
`ifdef BUZZER_ARBITER_GAP_EN
                    w_state_next = S_GAP;
                    w_grant_next = 3'b000;
                    w_gap_next   = '0;
`else
                    if (req != 3'b000) begin
                        // Direct handover: the owner has no request or a
                        // higher one exists, so w_req_first is a new source.
                        w_grant_next = w_req_first;
                        w_note_next  = w_first_note;
                        w_hold_next  = '0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_grant_next = 3'b000;
                    end
`endif
                end else if (w_own_req && !w_higher_req && (w_owner_note != r_note)) begin
                    // A new note from the owner restarts the hold window.
                    w_note_next = w_owner_note;
                    w_hold_next = '0;
                end else if (!w_eligible) begin
                    w_hold_next = r_hold_cnt + CNT_W'(1);
                end
            end
`ifdef BUZZER_ARBITER_GAP_EN
            S_GAP: begin
                if (r_gap_cnt >= GAP_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 3'b000;
            r_note     <= 4'd0;
            r_play     <= 1'b0;
            r_busy     <= 1'b0;
            r_preempt  <= 3'b000;
            r_hold_cnt <= '0;
`ifdef BUZZER_ARBITER_GAP_EN
            r_gap_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_note     <= w_note_next;
            r_play     <= (w_grant_next != 3'b000);
            r_busy     <= (w_state_next != S_IDLE);
            r_preempt  <= w_preempt_next;
            r_hold_cnt <= w_hold_next;
`ifdef BUZZER_ARBITER_GAP_EN
            r_gap_cnt  <= w_gap_next;
`endif
        end
    end

    assign grant     = r_grant;
    assign note_out  = r_note;
    assign play_out  = r_play;
    assign busy      = r_busy;
    assign preempted = r_preempt;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buzzer_arbiter
//
// Directed bench for buzzer_arbiter with MIN_HOLD=4, GAP_CYCLES=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_buzzer_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] note_in;
    logic [2:0]  grant;
    logic [3:0]  note_out;
    logic        play_out;
    logic        busy;
    logic [2:0]  preempted;

    int total = 0;
    int bad   = 0;

    buzzer_arbiter #(
        .MIN_HOLD   (4),
        .GAP_CYCLES (3),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .note_in   (note_in),
        .grant     (grant),
        .note_out  (note_out),
        .play_out  (play_out),
        .busy      (busy),
        .preempted (preempted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b000; note_in = 12'h000;
        step(); step();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", grant); end
        total++; if (note_out !== 4'd0) begin bad++; $display("FAIL reset_note: got %0d want 0", note_out); end
        total++; if (play_out !== 1'b0) begin bad++; $display("FAIL reset_play: got %b want 0", play_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (preempted !== 3'b000) begin bad++; $display("FAIL reset_preempted: got %b want 000", preempted); end
        rst = 1'b0;
        step();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL idle_grant: got %b want 000", grant); end
        $display("test_reset: done");
    endtask

    // Source 2 alone, held 10 cycles, then dropped.
    task automatic test_long_note();
        req = 3'b100; note_in = 12'h500;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++; if (grant !== 3'b100) begin bad++; $display("FAIL long_grant[%0d]: got %b want 100", i, grant); end
            total++; if (play_out !== 1'b1) begin bad++; $display("FAIL long_play[%0d]: got %b want 1", i, play_out); end
        end
        total++; if (note_out !== 4'd5) begin bad++; $display("FAIL long_note: got %0d want 5", note_out); end
        req = 3'b000;
        step();
        total++; if (play_out !== 1'b0) begin bad++; $display("FAIL long_release_play: got %b want 0", play_out); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL long_release_grant: got %b want 000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL long_release_busy: got %b want 0", busy); end
        total++; if (preempted !== 3'b000) begin bad++; $display("FAIL long_release_preempted: got %b want 000", preempted); end
        step();
        $display("test_long_note: done");
    endtask

    // One-cycle keyboard tap must sound MIN_HOLD+1 = 5 cycles.
    task automatic test_tap();
        int high_cnt;
        high_cnt = 0;
        req = 3'b001; note_in = 12'h002;
        step();
        req = 3'b000;
        total++; if (note_out !== 4'd2) begin bad++; $display("FAIL tap_note: got %0d want 2", note_out); end
        if (play_out === 1'b1) high_cnt++;
        for (int i = 0; i < 7; i++) begin
            step();
            if (play_out === 1'b1) high_cnt++;
            total++; if (preempted !== 3'b000) begin bad++; $display("FAIL tap_preempted[%0d]: got %b want 000", i, preempted); end
        end
        total++; if (high_cnt !== 5) begin bad++; $display("FAIL tap_length: got %0d want 5", high_cnt); end
        total++; if (play_out !== 1'b0) begin bad++; $display("FAIL tap_end_play: got %b want 0", play_out); end
        $display("test_tap: done");
    endtask

    // Source 2 owns; keyboard requests one cycle later and takes over at eligibility.
    task automatic test_preempt();
        req = 3'b100; note_in = 12'h509;
        step();
        total++; if (grant !== 3'b100) begin bad++; $display("FAIL pre_first_grant: got %b want 100", grant); end
        req = 3'b101;
        for (int i = 2; i <= 5; i++) begin
            step();
            total++; if (grant !== 3'b100) begin bad++; $display("FAIL pre_hold_grant[%0d]: got %b want 100", i, grant); end
            total++; if (preempted !== 3'b000) begin bad++; $display("FAIL pre_hold_pulse[%0d]: got %b want 000", i, preempted); end
        end
        step();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL pre_new_grant: got %b want 001", grant); end
        total++; if (play_out !== 1'b1) begin bad++; $display("FAIL pre_no_gap: got %b want 1", play_out); end
        total++; if (note_out !== 4'd9) begin bad++; $display("FAIL pre_new_note: got %0d want 9", note_out); end
        total++; if (preempted !== 3'b100) begin bad++; $display("FAIL pre_pulse: got %b want 100", preempted); end
        step();
        total++; if (preempted !== 3'b000) begin bad++; $display("FAIL pre_pulse_end: got %b want 000", preempted); end
        req = 3'b000;
        for (int i = 0; i < 8; i++) step();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL pre_idle: got %b want 000", grant); end
        $display("test_preempt: done");
    endtask

    // Owner 1 changes note at hold_cnt=3; the hold window restarts.
    task automatic test_note_change();
        req = 3'b010; note_in = 12'h030;
        for (int i = 0; i < 4; i++) step();
        total++; if (note_out !== 4'd3) begin bad++; $display("FAIL nc_first_note: got %0d want 3", note_out); end
        note_in = 12'h072;
        step();
        total++; if (note_out !== 4'd7) begin bad++; $display("FAIL nc_changed_note: got %0d want 7", note_out); end
        req = 3'b011;
        for (int i = 6; i <= 9; i++) begin
            step();
            total++; if (grant !== 3'b010) begin bad++; $display("FAIL nc_hold_grant[%0d]: got %b want 010", i, grant); end
        end
        step();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL nc_takeover: got %b want 001", grant); end
        total++; if (note_out !== 4'd2) begin bad++; $display("FAIL nc_takeover_note: got %0d want 2", note_out); end
        total++; if (preempted !== 3'b010) begin bad++; $display("FAIL nc_pulse: got %b want 010", preempted); end
        req = 3'b000;
        for (int i = 0; i < 8; i++) step();
        $display("test_note_change: done");
    endtask

    // Owner 1 releases while source 2 waits: 3 gap cycles, 1 idle cycle, then grant.
    task automatic test_gap();
        req = 3'b110; note_in = 12'h530;
        step();
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL gap_first_grant: got %b want 010", grant); end
        req = 3'b100;
        for (int i = 0; i < 4; i++) step();
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL gap_hold_grant: got %b want 010", grant); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (play_out !== 1'b0) begin bad++; $display("FAIL gap_play[%0d]: got %b want 0", i, play_out); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy[%0d]: got %b want 1", i, busy); end
        end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_idle_busy: got %b want 0", busy); end
        total++; if (play_out !== 1'b0) begin bad++; $display("FAIL gap_idle_play: got %b want 0", play_out); end
        step();
        total++; if (grant !== 3'b100) begin bad++; $display("FAIL gap_next_grant: got %b want 100", grant); end
        total++; if (note_out !== 4'd5) begin bad++; $display("FAIL gap_next_note: got %0d want 5", note_out); end
        req = 3'b000;
        for (int i = 0; i < 12; i++) step();
        $display("test_gap: done");
    endtask

    // Async reset while playing, then a pending request is granted normally.
    task automatic test_rst_mid();
        req = 3'b010; note_in = 12'h040;
        step(); step(); step();
        total++; if (play_out !== 1'b1) begin bad++; $display("FAIL rst_pre_play: got %b want 1", play_out); end
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL rst_async_grant: got %b want 000", grant); end
        total++; if (note_out !== 4'd0) begin bad++; $display("FAIL rst_async_note: got %0d want 0", note_out); end
        total++; if (play_out !== 1'b0) begin bad++; $display("FAIL rst_async_play: got %b want 0", play_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        step();
        rst = 1'b0;
        step();
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL rst_regrant: got %b want 010", grant); end
        total++; if (note_out !== 4'd4) begin bad++; $display("FAIL rst_regrant_note: got %0d want 4", note_out); end
        total++; if (play_out !== 1'b1) begin bad++; $display("FAIL rst_regrant_play: got %b want 1", play_out); end
        req = 3'b000;
        $display("test_rst_mid: done");
    endtask

    initial begin
        test_reset();
`ifdef BUZZER_ARBITER_GAP_EN
        test_gap();
`else
        test_long_note();
        test_tap();
        test_preempt();
        test_note_change();
`endif
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
